// File: rtl/id_stage.sv
// Instruction-decode stage: decodes the IF/ID instruction, reads operands from
// the register file (with write-through from writeback), resolves branches
// for fetch and registers the decoded bundle into the ID/EX pipeline register.
module id_stage #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       instruction,
  input  logic              wb_en,
  input  logic [4:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_val,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_addr,
  output logic [4:0]        src1,
  output logic [4:0]        src2,
  output logic              two_src,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] st_val,
  output logic [4:0]        dest,
  output logic [3:0]        exe_cmd,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en_out
);

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  localparam logic [3:0] EXE_ADD = 4'b0001;
  localparam logic [3:0] EXE_SUB = 4'b0010;
  localparam logic [3:0] EXE_AND = 4'b0011;
  localparam logic [3:0] EXE_OR  = 4'b0100;
  localparam logic [3:0] EXE_NOR = 4'b0101;
  localparam logic [3:0] EXE_XOR = 4'b0110;
  localparam logic [3:0] EXE_SHL = 4'b0111;
  localparam logic [3:0] EXE_SRA = 4'b1000;
  localparam logic [3:0] EXE_SRL = 4'b1001;

  logic [5:0]        opcode;
  logic [4:0]        f_dest;
  logic [DATA_W-1:0] imm_sext;
  logic              bubble;

  assign opcode   = instruction[31:26];
  assign f_dest   = instruction[25:21];
  assign src1     = instruction[20:16];
  assign src2     = instruction[15:11];
  assign imm_sext = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
  assign bubble   = flush | freeze;

  // Register file; R0 is never written so it stays at its reset value of 0.
  logic [DATA_W-1:0] rf_q [REG_COUNT];

  // Writeback port, independent of flush/freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_dest != 5'd0)) begin
      rf_q[wb_dest] <= wb_val;
    end
  end

  // Asynchronous reads with write-through of the value being written this cycle.
  logic              wb_live;
  logic [DATA_W-1:0] rd_s1, rd_s2, rd_dst;

  assign wb_live = wb_en && (wb_dest != 5'd0);
  assign rd_s1   = (src1 == 5'd0)   ? '0 : (wb_live && wb_dest == src1)   ? wb_val : rf_q[src1];
  assign rd_s2   = (src2 == 5'd0)   ? '0 : (wb_live && wb_dest == src2)   ? wb_val : rf_q[src2];
  assign rd_dst  = (f_dest == 5'd0) ? '0 : (wb_live && wb_dest == f_dest) ? wb_val : rf_q[f_dest];

  logic [3:0]        dec_exe;
  logic              dec_wb, dec_mr, dec_mw, dec_two, dec_cond, reg_op;
  logic [DATA_W-1:0] dec_v2, dec_st;

  // Opcode decode into EX/MEM/WB control, second operand and branch condition.
  always_comb begin
    dec_exe  = 4'b0000;
    dec_wb   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    dec_two  = 1'b0;
    dec_cond = 1'b0;
    dec_v2   = '0;
    dec_st   = '0;
    reg_op   = 1'b0;
    case (opcode)
      OP_ADD:         begin dec_exe = EXE_ADD; reg_op = 1'b1; end
      OP_SUB:         begin dec_exe = EXE_SUB; reg_op = 1'b1; end
      OP_AND:         begin dec_exe = EXE_AND; reg_op = 1'b1; end
      OP_OR:          begin dec_exe = EXE_OR;  reg_op = 1'b1; end
      OP_NOR:         begin dec_exe = EXE_NOR; reg_op = 1'b1; end
      OP_XOR:         begin dec_exe = EXE_XOR; reg_op = 1'b1; end
      OP_SLA, OP_SLL: begin dec_exe = EXE_SHL; reg_op = 1'b1; end
      OP_SRA:         begin dec_exe = EXE_SRA; reg_op = 1'b1; end
      OP_SRL:         begin dec_exe = EXE_SRL; reg_op = 1'b1; end
      OP_ADDI: begin
        dec_exe = EXE_ADD;
        dec_wb  = 1'b1;
        dec_v2  = imm_sext;
      end
      OP_SUBI: begin
        dec_exe = EXE_SUB;
        dec_wb  = 1'b1;
        dec_v2  = imm_sext;
      end
      OP_LD: begin
        dec_exe = EXE_ADD;
        dec_mr  = 1'b1;
        dec_wb  = 1'b1;
        dec_v2  = imm_sext;
      end
      OP_ST: begin
        dec_exe = EXE_ADD;
        dec_mw  = 1'b1;
        dec_two = 1'b1;
        dec_v2  = imm_sext;
        dec_st  = rd_dst;
      end
      OP_BEZ: dec_cond = (rd_s1 == '0);
      OP_BNE: begin
        dec_cond = (rd_s1 != rd_s2);
        dec_two  = 1'b1;
      end
      OP_JMP: dec_cond = 1'b1;
      default: ;
    endcase
    if (reg_op) begin
      dec_wb  = 1'b1;
      dec_two = 1'b1;
      dec_v2  = rd_s2;
    end
  end

  assign two_src  = dec_two;
  assign br_taken = dec_cond & ~bubble;
  assign br_addr  = pc_in + {imm_sext[DATA_W-3:0], 2'b00};

  logic [DATA_W-1:0] pc_q, val1_q, val2_q, st_q;
  logic [4:0]        dest_q;
  logic [3:0]        exe_q;
  logic              mr_q, mw_q, wb_q;

  // ID/EX pipeline register; flush/freeze load an all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      pc_q   <= '0;
      val1_q <= '0;
      val2_q <= '0;
      st_q   <= '0;
      dest_q <= '0;
      exe_q  <= '0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      wb_q   <= 1'b0;
    end else begin
      pc_q   <= pc_in;
      val1_q <= rd_s1;
      val2_q <= dec_v2;
      st_q   <= dec_st;
      dest_q <= f_dest;
      exe_q  <= dec_exe;
      mr_q   <= dec_mr;
      mw_q   <= dec_mw;
      wb_q   <= dec_wb;
    end
  end

  assign pc_out    = pc_q;
  assign val1      = val1_q;
  assign val2      = val2_q;
  assign st_val    = st_q;
  assign dest      = dest_q;
  assign exe_cmd   = exe_q;
  assign mem_r_en  = mr_q;
  assign mem_w_en  = mw_q;
  assign wb_en_out = wb_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by random instruction and
// writeback traffic, compared against an architectural model of decode.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, flush, freeze, wb_en;
  logic [31:0] pc_in, instruction, wb_val;
  logic [4:0]  wb_dest;
  logic        br_taken, two_src, mem_r_en, mem_w_en, wb_en_out;
  logic [31:0] br_addr, pc_out, val1, val2, st_val;
  logic [4:0]  src1, src2, dest;
  logic [3:0]  exe_cmd;

  id_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .pc_in(pc_in), .instruction(instruction),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
    .br_taken(br_taken), .br_addr(br_addr), .src1(src1), .src2(src2),
    .two_src(two_src), .pc_out(pc_out), .val1(val1), .val2(val2),
    .st_val(st_val), .dest(dest), .exe_cmd(exe_cmd),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en_out(wb_en_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural register state.
  logic [31:0] m_rf [32];

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_dest == a) return wb_val;
    return m_rf[a];
  endfunction

  function automatic logic [3:0] m_exe(input int op);
    case (op)
      1, 32, 36, 37: return 4'd1;
      3, 33:         return 4'd2;
      5:             return 4'd3;
      6:             return 4'd4;
      7:             return 4'd5;
      8:             return 4'd6;
      9, 10:         return 4'd7;
      11:            return 4'd8;
      12:            return 4'd9;
      default:       return 4'd0;
    endcase
  endfunction

  // One decode cycle: check combinational outputs mid-cycle, then the
  // ID/EX outputs after the edge, then retire the writeback into the model.
  task automatic cycle();
    int          op;
    logic [4:0]  s1, s2, d;
    logic [31:0] sx, v1, e_v2, e_st;
    logic        bub, is_reg, is_imm, taken, two;
    logic        e_wb, e_mr, e_mw;
    logic [31:0] e_pc, e_v1;
    logic [4:0]  e_dest;
    logic [3:0]  e_exe;
    #2;
    op  = int'(instruction[31:26]);
    d   = instruction[25:21];
    s1  = instruction[20:16];
    s2  = instruction[15:11];
    sx  = 32'(signed'(instruction[15:0]));
    bub = flush || freeze;
    v1  = m_rd(s1);
    is_reg = op inside {1, 3, 5, 6, 7, 8, 9, 10, 11, 12};
    is_imm = op inside {32, 33, 36, 37};
    taken  = (op == 40 && v1 == 0) || (op == 41 && v1 != m_rd(s2)) || (op == 42);
    taken  = taken && !bub;
    two    = is_reg || op == 37 || op == 41;
    chk("src1", 32'(src1), 32'(s1));
    chk("src2", 32'(src2), 32'(s2));
    chk("two_src", 32'(two_src), 32'(two));
    chk("br_taken", 32'(br_taken), 32'(taken));
    chk("br_addr", br_addr, pc_in + sx * 4);

    e_pc = pc_in; e_v1 = v1; e_dest = d; e_exe = m_exe(op);
    e_wb = is_reg || op inside {32, 33, 36};
    e_mr = (op == 36);
    e_mw = (op == 37);
    e_v2 = is_reg ? m_rd(s2) : sx;
    e_st = m_rd(d);
    if (bub) begin
      e_pc = 0; e_v1 = 0; e_dest = 0; e_exe = 0; e_wb = 0; e_mr = 0; e_mw = 0;
      e_v2 = 0; e_st = 0;
    end

    @(posedge clk);
    #1;
    if (wb_en && wb_dest != 0) m_rf[wb_dest] = wb_val;
    chk("pc_out", pc_out, e_pc);
    chk("val1", val1, e_v1);
    chk("dest", 32'(dest), 32'(e_dest));
    chk("exe_cmd", 32'(exe_cmd), 32'(e_exe));
    chk("wb_en_out", 32'(wb_en_out), 32'(e_wb));
    chk("mem_r_en", 32'(mem_r_en), 32'(e_mr));
    chk("mem_w_en", 32'(mem_w_en), 32'(e_mw));
    if (bub || is_reg || is_imm) chk("val2", val2, e_v2);
    if (bub || op == 37) chk("st_val", st_val, e_st);
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
    instruction = 32'd0;
    wb_en = 1'b1; wb_dest = r; wb_val = v;
    cycle();
    wb_en = 1'b0;
  endtask

  function automatic logic [31:0] enc(input int op, input int d, input int a, input int b, input int imm);
    return (32'(op) << 26) | (32'(d) << 21) | (32'(a) << 16) | (32'(b) << 11) | 32'(imm & 16'hFFFF);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_regout"}, pc_out | val1 | val2 | st_val | 32'(dest) | 32'(exe_cmd)
        | 32'(mem_r_en) | 32'(mem_w_en) | 32'(wb_en_out), 32'd0);
  endtask

  int ops[18] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    rst = 1'b1; flush = 0; freeze = 0; pc_in = 0; instruction = 0;
    wb_en = 0; wb_dest = 0; wb_val = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_all_zero("reset");

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);

    instruction = 32'h04611000; pc_in = 32'd12;
    cycle();
    chk("add_val1", val1, 32'd5);
    chk("add_val2", val2, 32'd7);
    chk("add_dest", 32'(dest), 32'd3);
    chk("add_exe", 32'(exe_cmd), 32'd1);
    chk("add_wb", 32'(wb_en_out), 32'd1);
    chk("add_pc", pc_out, 32'd12);

    wb_en = 1; wb_dest = 1; wb_val = 9;
    cycle();
    chk("wt_val1", val1, 32'd9);
    wb_en = 1; wb_dest = 0; wb_val = 32'hFF;
    instruction = enc(1, 3, 0, 2, 0);
    cycle();
    chk("r0_val1", val1, 32'd0);
    wb_en = 0;
    wb_write(5'd1, 32'd5);

    instruction = enc(32, 4, 1, 0, 16'hFFFC);
    cycle();
    chk("addi_val2", val2, 32'hFFFFFFFC);
    chk("addi_exe", 32'(exe_cmd), 32'd1);
    instruction = enc(37, 2, 1, 0, 0);
    cycle();
    chk("st_val", st_val, 32'd7);
    chk("st_mw", 32'(mem_w_en), 32'd1);
    chk("st_wb", 32'(wb_en_out), 32'd0);

    wb_write(5'd1, 32'd0);
    instruction = enc(40, 0, 1, 0, 3); pc_in = 32'd8;
    #2;
    chk("bez_taken", 32'(br_taken), 32'd1);
    chk("bez_addr", br_addr, 32'd20);
    cycle();
    chk("bez_ctl", 32'(exe_cmd) | 32'(wb_en_out) | 32'(mem_r_en) | 32'(mem_w_en), 32'd0);

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd5);
    instruction = enc(41, 0, 1, 2, 3);
    #2;
    chk("bne_eq", 32'(br_taken), 32'd0);
    cycle();
    instruction = enc(42, 0, 0, 0, 16'hFFFF); pc_in = 32'd8;
    #2;
    chk("jmp_addr", br_addr, 32'd4);
    cycle();

    wb_write(5'd1, 32'd0);
    instruction = enc(40, 0, 1, 0, 3); pc_in = 32'd8;
    freeze = 1; wb_en = 1; wb_dest = 5; wb_val = 3;
    #2;
    chk("frz_taken", 32'(br_taken), 32'd0);
    cycle();
    chk_all_zero("freeze");
    freeze = 0; flush = 1; wb_en = 0;
    #2;
    chk("fl_taken", 32'(br_taken), 32'd0);
    cycle();
    chk_all_zero("flush");
    flush = 0;
    instruction = enc(1, 6, 5, 0, 0);
    cycle();
    chk("r5_landed", val1, 32'd3);

    for (int n = 0; n < 400; n++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 17)];
      instruction = enc(op, $urandom_range(0, 31), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom);
      pc_in  = $urandom;
      flush  = ($urandom_range(0, 9) == 0);
      freeze = ($urandom_range(0, 9) == 0);
      wb_en  = $urandom_range(0, 1);
      wb_dest = 5'($urandom_range(0, 7));
      wb_val  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      cycle();
    end
    flush = 0; freeze = 0; wb_en = 0;

    wb_write(5'd1, 32'd11);
    wb_write(5'd2, 32'd22);
    instruction = 32'h04611000; pc_in = 32'd12;
    cycle();
    wb_en = 1; wb_dest = 3; wb_val = 32'h55;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    wb_en = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    instruction = enc(1, 4, 1, 3, 0);
    cycle();
    chk("rst_r1", val1, 32'd0);
    chk("rst_r3", val2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
